// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
// Holds the measurement state encoding, the synchroniser depth and the
// saturating increment used by the edge counter.
package ro_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE
   } meas_state_t;

   localparam int SYNC_STAGES = 2;

   // Working width of sat_inc; counters up to 32 bits wide can use it.
   localparam int SAT_W = 32;

   // Returns val+1, but never goes past max_val.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] max_val);
      if (val >= max_val) begin
         return max_val;
      end
      return val + 1'b1;
   endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchroniser with rising-edge detector for one asynchronous tap.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset
//   clr_i      synchronous clear of all history (held while the meter is idle)
//   d_i        asynchronous input
//   rise_o     high for one cycle after a synchronised 0->1 transition
module ro_edge_sync
   import ro_meas_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic clr_i,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the tap through the synchroniser; prev_q holds the previous
   // synchronised value so a rising edge can be spotted. Clearing keeps the
   // chain at zero so a new run never sees stale history.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else if (clr_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: selects one of NUM_CH oscillator taps,
// enables the oscillators only while measuring, lets them settle, then counts
// synchronised rising edges over a programmable window of clock cycles.
// Ports:
//   wb_clk_i, wb_rst_ni  clock and asynchronous active-low reset
//   ro_tap_i             asynchronous oscillator taps
//   sel_i, gate_i        tap select and window length, latched on start
//   start_i, abort_i     measurement request and cancel
//   ro_en_o, busy_o      oscillator enable and measurement-in-progress
//   done_o               one-cycle pulse when count_o/ovf_o update
//   count_o, ovf_o       last result and its saturation flag
module ro_freq_meter
   import ro_meas_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int CNT_W  = 24,
   parameter int GATE_W = 20,
   parameter int SETTLE = 4,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [NUM_CH-1:0] ro_tap_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [GATE_W-1:0] gate_i,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              ro_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   meas_state_t       state_q, state_d;
   logic [SEL_W-1:0]  sel_q;
   logic [GATE_W-1:0] gate_q;
   logic [GATE_W-1:0] timer_q;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              ovf_run_q, ovf_run_d;
   logic              tap_mux;
   logic              rise;
   logic              accept;
   logic              finish;
   logic              timer_zero;

   // Tap mux driven by the latched select so sel_i may change mid-run.
   // Selects beyond NUM_CH-1 read as a quiet tap.
   always_comb begin
      tap_mux = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_q == SEL_W'(i)) begin
            tap_mux = ro_tap_i[i];
         end
      end
   end

   ro_edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .clr_i     (state_q == ST_IDLE),
      .d_i       (tap_mux),
      .rise_o    (rise)
   );

   assign timer_zero = (timer_q == '0);

   // State register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Abort beats both a simultaneous start and the final
   // gate cycle, so an aborted run never produces done_o. A zero-length
   // window is accepted but answered directly from IDLE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               accept = 1'b1;
               if (gate_i != '0) begin
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_GATE;
            end
         end
         ST_GATE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_IDLE;
               finish  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Saturating edge count including this cycle's edge, so the last gate
   // cycle is counted when the result is captured. Once the counter sits at
   // its maximum, any further edge raises the sticky run overflow.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      ovf_run_d  = ovf_run_q;
      if (state_q == ST_GATE && rise) begin
         edge_cnt_d = CNT_W'(sat_inc(SAT_W'(edge_cnt_q), SAT_W'(CNT_MAX)));
         ovf_run_d  = ovf_run_q | (edge_cnt_q == CNT_MAX);
      end
   end

   // Datapath: one down-counter times the settle phase and then the gate
   // window; the result registers only move on a completed or zero-length run.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sel_q      <= '0;
         gate_q     <= '0;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         ovf_run_q  <= 1'b0;
         done_o     <= 1'b0;
         count_o    <= '0;
         ovf_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (accept) begin
            sel_q      <= sel_i;
            gate_q     <= gate_i;
            timer_q    <= GATE_W'(SETTLE - 1);
            edge_cnt_q <= '0;
            ovf_run_q  <= 1'b0;
            if (gate_i == '0) begin
               done_o  <= 1'b1;
               count_o <= '0;
               ovf_o   <= 1'b0;
            end
         end else begin
            if (state_q == ST_SETTLE) begin
               timer_q <= timer_zero ? (gate_q - 1'b1) : (timer_q - 1'b1);
            end
            if (state_q == ST_GATE) begin
               timer_q    <= timer_q - 1'b1;
               edge_cnt_q <= edge_cnt_d;
               ovf_run_q  <= ovf_run_d;
            end
            if (finish) begin
               done_o  <= 1'b1;
               count_o <= edge_cnt_d;
               ovf_o   <= ovf_run_d;
            end
         end
      end
   end

   assign ro_en_o = (state_q != ST_IDLE);
   assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed testbench for ro_freq_meter with an 8-bit result so saturation
// is reachable. Each tap is a square wave whose period in clock cycles is
// fixed per channel; edges land on the falling clock edge.
module tb_ro_freq_meter;

   localparam int NUM_CH = 16;
   localparam int CNT_W  = 8;
   localparam int GATE_W = 20;
   localparam int SETTLE = 4;
   localparam int SEL_W  = 4;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_ni;
   logic [NUM_CH-1:0] ro_tap_i = '0;
   logic [SEL_W-1:0]  sel_i;
   logic [GATE_W-1:0] gate_i;
   logic              start_i;
   logic              abort_i;
   logic              ro_en_o;
   logic              busy_o;
   logic              done_o;
   logic [CNT_W-1:0]  count_o;
   logic              ovf_o;

   int errors = 0;
   int checks = 0;
   int phase[NUM_CH] = '{default: 0};

   ro_freq_meter #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .GATE_W (GATE_W),
      .SETTLE (SETTLE)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .ro_tap_i  (ro_tap_i),
      .sel_i     (sel_i),
      .gate_i    (gate_i),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .ro_en_o   (ro_en_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .count_o   (count_o),
      .ovf_o     (ovf_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Channel ch runs with period ch+1 cycles (channels 0 and 1 use 17).
   function automatic int period_of(input int ch);
      return (ch < 2) ? 17 : ch + 1;
   endfunction

   // Tap generator: one rising edge per period, high for period/2 cycles.
   always @(negedge wb_clk_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         phase[ch] = (phase[ch] + 1) % period_of(ch);
         ro_tap_i[ch] = (phase[ch] < period_of(ch) / 2);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues a start and waits (bounded) for done_o. For non-zero windows it
   // also pokes start_i, sel_i and gate_i mid-run, which must be ignored.
   task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [GATE_W-1:0] gate,
                                output int lat, output logic busy_seen);
      sel_i     = sel;
      gate_i    = gate;
      start_i   = 1'b1;
      lat       = -1;
      busy_seen = 1'b0;
      for (int n = 1; n <= SETTLE + int'(gate) + 20; n++) begin
         @(posedge wb_clk_i);
         #1;
         if (n == 1) start_i = 1'b0;
         if (gate != '0 && n == 3) begin
            start_i = 1'b1;
            sel_i   = sel + 4'd1;
            gate_i  = gate + 20'd7;
         end
         if (n == 4) start_i = 1'b0;
         if (busy_o || ro_en_o) busy_seen = 1'b1;
         if (done_o) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      logic bs;
      int   done_cnt;

      wb_rst_ni = 1'b0;
      start_i   = 1'b0;
      abort_i   = 1'b0;
      sel_i     = '0;
      gate_i    = '0;

      repeat (3) @(posedge wb_clk_i);
      #1;
      checkOutput("reset ro_en", 32'(ro_en_o), 0);
      checkOutput("reset busy", 32'(busy_o), 0);
      checkOutput("reset done", 32'(done_o), 0);
      checkOutput("reset count", 32'(count_o), 0);
      checkOutput("reset ovf", 32'(ovf_o), 0);
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;

      // Channel 3, period 4, 1000-cycle window; mid-run poke selects channel 4.
      applyStimulus(4'd3, 20'd1000, lat, bs);
      checkOutput("main latency", 32'(lat), SETTLE + 1001);
      checkOutput("main count", 32'(count_o), 250);
      checkOutput("main ovf", 32'(ovf_o), 0);
      checkOutput("main busy seen", 32'(bs), 1);
      @(posedge wb_clk_i);
      #1;
      checkOutput("done pulse width", 32'(done_o), 0);
      checkOutput("idle after run", 32'(busy_o), 0);

      // Zero-length window.
      applyStimulus(4'd3, 20'd0, lat, bs);
      checkOutput("gate0 latency", 32'(lat), 1);
      checkOutput("gate0 count", 32'(count_o), 0);
      checkOutput("gate0 ovf", 32'(ovf_o), 0);
      checkOutput("gate0 busy/ro_en seen", 32'(bs), 0);

      // Channel 2, period 3: 400 edges saturate the 8-bit counter.
      applyStimulus(4'd2, 20'd1200, lat, bs);
      checkOutput("sat latency", 32'(lat), SETTLE + 1201);
      checkOutput("sat count", 32'(count_o), 255);
      checkOutput("sat ovf", 32'(ovf_o), 1);

      applyStimulus(4'd2, 20'd30, lat, bs);
      checkOutput("post-sat count", 32'(count_o), 10);
      checkOutput("post-sat ovf", 32'(ovf_o), 0);

      // Abort 50 cycles into the gate window.
      sel_i   = 4'd3;
      gate_i  = 20'd1000;
      start_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      start_i = 1'b0;
      repeat (SETTLE + 50) @(posedge wb_clk_i);
      #1;
      checkOutput("pre-abort busy", 32'(busy_o), 1);
      abort_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      abort_i = 1'b0;
      checkOutput("abort busy", 32'(busy_o), 0);
      checkOutput("abort ro_en", 32'(ro_en_o), 0);
      done_cnt = 32'(done_o);
      for (int n = 0; n < 1100; n++) begin
         @(posedge wb_clk_i);
         #1;
         if (done_o) done_cnt++;
      end
      checkOutput("abort no done", 32'(done_cnt), 0);
      checkOutput("abort count kept", 32'(count_o), 10);

      // Abort together with start in IDLE drops the start.
      sel_i   = 4'd3;
      gate_i  = 20'd10;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      checkOutput("abort+start busy", 32'(busy_o), 0);
      done_cnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge wb_clk_i);
         #1;
         if (done_o) done_cnt++;
      end
      checkOutput("abort+start no done", 32'(done_cnt), 0);

      // Asynchronous reset in the middle of the gate window.
      sel_i   = 4'd3;
      gate_i  = 20'd1000;
      start_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      start_i = 1'b0;
      repeat (100) @(posedge wb_clk_i);
      #2;
      wb_rst_ni = 1'b0;
      #1;
      checkOutput("midrst ro_en", 32'(ro_en_o), 0);
      checkOutput("midrst busy", 32'(busy_o), 0);
      checkOutput("midrst done", 32'(done_o), 0);
      checkOutput("midrst count", 32'(count_o), 0);
      checkOutput("midrst ovf", 32'(ovf_o), 0);
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;

      // Fresh run on channel 4, period 5; mid-run poke selects channel 5.
      applyStimulus(4'd4, 20'd100, lat, bs);
      checkOutput("fresh latency", 32'(lat), SETTLE + 101);
      checkOutput("fresh count", 32'(count_o), 20);
      checkOutput("fresh ovf", 32'(ovf_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
